pb_conditioner: RTL and testbench
=================================

# pb_conditioner

Front-end conditioning stage for the calculator's push-button bus. Synchronizes each raw button input and debounces it with a per-button counter FSM. Emits a clean level and a single-cycle press strobe per button, which the key, opcode and register decoders consume in place of raw `pb`. Optional auto-repeat re-issues strobes while a button is held.

## Interface
Parameters:
- `NBTN`, 20: number of buttons.
- `DB_CNT`, 1000: consecutive cycles a synchronized input must disagree with the debounced level before the level changes; must be ≥ 1.
- `REP_DELAY`, 50000: cycles from the first strobe to the first repeat strobe; `AUTOREPEAT_EN` only.
- `REP_PERIOD`, 10000: cycles between later repeat strobes; `AUTOREPEAT_EN` only.
- `REP_MASK`, `'0`: NBTN-bit mask; bit i = 1 enables repeat on button i.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `nrst`  in  1  reset; one clock, asynchronous, active-high (1 = reset asserted).
- `pb_raw`  in  NBTN  raw, asynchronous button inputs; 1 = pressed.
- `pb_level`  out  NBTN  debounced level per button.
- `pb_pulse`  out  NBTN  one-cycle press strobe per button.
- `any_press`  out  1  OR of `pb_level`.
- `multi_press`  out  1  two or more `pb_level` bits are high.

## Operation
- Each button has its own 2-flop synchronizer (`s1`, `s2`), counter `cnt` of width `$clog2(DB_CNT+1)`, and a 2-bit FSM.
- FSM states:
  - LO: level 0, `cnt`=0. If `s2`=1, go to CHK_HI with `cnt`=1.
  - CHK_HI: if `s2`=0, go to LO and clear `cnt`. Otherwise, when `cnt`=DB_CNT, go to HI: level←1, pulse←1, `cnt`←0. Otherwise `cnt`++.
  - HI: level 1. If `s2`=0, go to CHK_LO with `cnt`=1.
  - CHK_LO: mirror of CHK_HI. Return to HI on `s2`=1. At `cnt`=DB_CNT, go to LO with level←0. No pulse on release.
- When DB_CNT=1, the CHK state is entered and exited on consecutive edges, so the level follows `s2` with one extra cycle.
- `pb_pulse[i]` is registered, high for exactly one cycle per accepted press.
- A glitch shorter than DB_CNT cycles of `s2` produces no level change and no pulse.
- Buttons are fully independent. Simultaneous presses produce simultaneous pulses; there is no priority logic. Arbitration is the consumer's job, and `multi_press` is provided for it.
- `any_press` and `multi_press` are combinational from the registered levels only.
- Reset, including mid-count or mid-hold: `s1`, `s2`, `cnt`, FSM=LO, `pb_level`=0, `pb_pulse`=0, all repeat counters=0. A button held through reset release is treated as a fresh press.

## Timing
- `pb_raw[i]` rises before edge E0 and stays stable. Then `s2`=1 after edge E1, and `pb_level[i]` and `pb_pulse[i]` are high in the cycle following edge E1+DB_CNT+1.
- Press latency is 2+DB_CNT cycles from the first sampling edge. Release latency is identical.
- A pulse is never wider than one cycle and is never issued while the FSM is in CHK_HI.
- Minimum press-to-press spacing is 2·DB_CNT+2 cycles (press, release, press).

## Configuration
- Macro: `PB_CONDITIONER_AUTOREPEAT_EN`.
- Defined:
  - A button with its `REP_MASK` bit set, still in HI, gets a repeat pulse REP_DELAY cycles after its initial pulse, then every REP_PERIOD cycles.
  - Leaving HI (entering CHK_LO) clears the repeat counter immediately.
  - A return from CHK_LO to HI restarts the REP_PERIOD count from zero; it does not resume it.
- Undefined: exactly one pulse per press. The repeat counters are not instantiated, and `REP_*` parameters are accepted but ignored.

## Structure
- Shared package `calc_pkg`:
  - `btn_state_t` enum {LO, CHK_HI, HI, CHK_LO}.
  - `NBTN_DEFAULT` = 20.
- Natural sub-module: `btn_debounce`, holding one button's synchronizer, counter, FSM and optional repeat counter. It is generated NBTN times.
- The top adds only the `any_press` and `multi_press` reduction.

## Test plan
Bench parameters: DB_CNT=4, REP_DELAY=20, REP_PERIOD=6.
- Raise `pb_raw[3]` cleanly and hold → `pb_level[3]` rises 6 cycles after the first sampling edge, a single 1-cycle `pb_pulse[3]`, all other bits 0.
- On `pb_raw[5]`, a 3-cycle high glitch, then low → `pb_level[5]` and `pb_pulse[5]` stay 0, and the FSM returns to LO.
- Press 10, release 10 cycles later, press again → two pulses and the level tracks both presses.
- Press buttons 0 and 7 on the same edge → pulses in the same cycle, and `multi_press`=1 while both are held.
- Hold `pb_raw[2]` and assert `nrst` for 2 cycles in HI, then release reset → outputs 0 immediately, then a fresh pulse 6 cycles after release.
- With the macro defined, `REP_MASK`[1]=1, hold 40 cycles → pulses at t0, t0+20, t0+26, t0+32, t0+38.
  - The same hold on a button whose `REP_MASK` bit is 0 → only one pulse.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator front end.
// The auto-repeat option is controlled by PB_CONDITIONER_AUTOREPEAT_EN.
package calc_pkg;

    typedef enum logic [1:0] {
        LO,
        CHK_HI,
        HI,
        CHK_LO
    } btn_state_t;

    localparam int NBTN_DEFAULT = 20;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, counter-based debounce FSM and, when
// PB_CONDITIONER_AUTOREPEAT_EN is defined, a repeat-strobe counter.
module btn_debounce
    import calc_pkg::*;
#(
    parameter int DB_CNT     = 1000,
    parameter int REP_DELAY  = 50000,
    parameter int REP_PERIOD = 10000,
    parameter bit REP_EN     = 1'b0
) (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_raw,
    output logic o_level,
    output logic o_pulse
);

    localparam int CW = $clog2(DB_CNT + 1);

    logic          r_s1;
    logic          r_s2;
    btn_state_t    r_state;
    btn_state_t    w_stateNext;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cntNext;
    logic          r_level;
    logic          w_levelNext;
    logic          w_pressPulse;
    logic          w_repPulse;
    logic          r_pulse;
    logic          w_cntDone;

    always_ff @(posedge i_clk or posedge i_nrst) begin
        if (i_nrst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge i_clk or posedge i_nrst) begin
        if (i_nrst) begin
            r_state <= LO;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_level <= w_levelNext;
            r_pulse <= w_pressPulse | w_repPulse;
        end
    end

    assign w_cntDone = (r_cnt == CW'(DB_CNT));

    // The level only moves after DB_CNT consecutive disagreeing samples.
    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_levelNext  = r_level;
        w_pressPulse = 1'b0;
        case (r_state)
            LO: begin
                w_levelNext = 1'b0;
                if (r_s2) begin
                    w_stateNext = CHK_HI;
                    w_cntNext   = CW'(1);
                end
            end
            CHK_HI: begin
                if (!r_s2) begin
                    w_stateNext = LO;
                    w_cntNext   = '0;
                end else if (w_cntDone) begin
                    w_stateNext  = HI;
                    w_levelNext  = 1'b1;
                    w_pressPulse = 1'b1;
                    w_cntNext    = '0;
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
            end
            HI: begin
                w_levelNext = 1'b1;
                if (!r_s2) begin
                    w_stateNext = CHK_LO;
                    w_cntNext   = CW'(1);
                end
            end
            CHK_LO: begin
                if (r_s2) begin
                    w_stateNext = HI;
                    w_cntNext   = '0;
                end else if (w_cntDone) begin
                    w_stateNext = LO;
                    w_levelNext = 1'b0;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
            end
            default: begin
                w_stateNext = LO;
                w_cntNext   = '0;
                w_levelNext = 1'b0;
            end
        endcase
    end

`ifdef PB_CONDITIONER_AUTOREPEAT_EN
    localparam int RW = $clog2(maxOf(REP_DELAY, REP_PERIOD) + 1);

    logic [RW-1:0] r_repCnt;
    logic          r_repFirst;
    logic [RW-1:0] w_repLast;
    logic          w_holdHi;

    assign w_holdHi   = (r_state == HI) && (w_stateNext == HI);
    assign w_repLast  = r_repFirst ? RW'(REP_DELAY - 1) : RW'(REP_PERIOD - 1);
    assign w_repPulse = REP_EN && w_holdHi && (r_repCnt == w_repLast);

    // A fresh press arms the long first delay; recovering from CHK_LO only
    // restarts the shorter period.
    always_ff @(posedge i_clk or posedge i_nrst) begin
        if (i_nrst) begin
            r_repCnt   <= '0;
            r_repFirst <= 1'b0;
        end else if (r_state == CHK_HI && w_stateNext == HI) begin
            r_repCnt   <= '0;
            r_repFirst <= 1'b1;
        end else if (r_state == CHK_LO && w_stateNext == HI) begin
            r_repCnt   <= '0;
            r_repFirst <= 1'b0;
        end else if (w_holdHi) begin
            if (r_repCnt == w_repLast) begin
                r_repCnt   <= '0;
                r_repFirst <= 1'b0;
            end else begin
                r_repCnt <= r_repCnt + 1'b1;
            end
        end else begin
            r_repCnt   <= '0;
            r_repFirst <= 1'b0;
        end
    end
`else
    logic w_unusedRep;
    assign w_unusedRep = ^{32'(REP_DELAY), 32'(REP_PERIOD), REP_EN};
    assign w_repPulse  = 1'b0;
`endif

    assign o_level = r_level;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/pb_conditioner.sv
// Push-button conditioner: one debouncer per button plus press summaries.
// Define PB_CONDITIONER_AUTOREPEAT_EN to enable masked auto-repeat strobes.
module pb_conditioner
    import calc_pkg::*;
#(
    parameter int              NBTN       = NBTN_DEFAULT,
    parameter int              DB_CNT     = 1000,
    parameter int              REP_DELAY  = 50000,
    parameter int              REP_PERIOD = 10000,
    parameter logic [NBTN-1:0] REP_MASK   = '0
) (
    input  logic            i_clk,
    input  logic            i_nrst,
    input  logic [NBTN-1:0] i_pb_raw,
    output logic [NBTN-1:0] o_pb_level,
    output logic [NBTN-1:0] o_pb_pulse,
    output logic            o_any_press,
    output logic            o_multi_press
);

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        btn_debounce #(
            .DB_CNT     (DB_CNT),
            .REP_DELAY  (REP_DELAY),
            .REP_PERIOD (REP_PERIOD),
            .REP_EN     (REP_MASK[i])
        ) u_btn (
            .i_clk   (i_clk),
            .i_nrst  (i_nrst),
            .i_raw   (i_pb_raw[i]),
            .o_level (o_pb_level[i]),
            .o_pulse (o_pb_pulse[i])
        );
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign o_any_press   = |o_pb_level;
    assign o_multi_press = |(o_pb_level & (o_pb_level - NBTN'(1)));

endmodule

// File: tb/tb_pb_conditioner.sv
// Directed self-checking bench for pb_conditioner (DB_CNT=4, REP 20/6).
// Repeat expectations follow PB_CONDITIONER_AUTOREPEAT_EN.
module tb_pb_conditioner;
    import calc_pkg::*;

    localparam int NBTN = 20;

    logic            clk;
    logic            nrst;
    logic [NBTN-1:0] pbRaw;
    logic [NBTN-1:0] pbLevel;
    logic [NBTN-1:0] pbPulse;
    logic            anyPress;
    logic            multiPress;

    int checks   = 0;
    int failures = 0;
    int pulseTally [NBTN];
    int offsets [$];

    pb_conditioner #(
        .NBTN       (NBTN),
        .DB_CNT     (4),
        .REP_DELAY  (20),
        .REP_PERIOD (6),
        .REP_MASK   (20'h00002)
    ) dut (
        .i_clk         (clk),
        .i_nrst        (nrst),
        .i_pb_raw      (pbRaw),
        .o_pb_level    (pbLevel),
        .o_pb_pulse    (pbPulse),
        .o_any_press   (anyPress),
        .o_multi_press (multiPress)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance whole cycles, sampling on falling edges and tallying strobes.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < NBTN; i++)
                if (pbPulse[i]) pulseTally[i]++;
        end
    endtask

    initial begin
        for (int i = 0; i < NBTN; i++) pulseTally[i] = 0;
        nrst  = 1'b1;
        pbRaw = '0;
        applyStimulus(3);
        nrst = 1'b0;
        applyStimulus(2);
        checkOutput("reset_level", 32'(pbLevel), 32'h0);
        checkOutput("reset_pulse", 32'(pbPulse), 32'h0);
        checkOutput("reset_any", 32'(anyPress), 32'h0);
        checkOutput("reset_multi", 32'(multiPress), 32'h0);

        // Clean press on button 3
        pbRaw = 20'h00008;
        applyStimulus(6);
        checkOutput("b3_level_early", 32'(pbLevel), 32'h0);
        applyStimulus(1);
        checkOutput("b3_level", 32'(pbLevel), 32'h00008);
        checkOutput("b3_pulse", 32'(pbPulse), 32'h00008);
        checkOutput("b3_any", 32'(anyPress), 32'h1);
        applyStimulus(1);
        checkOutput("b3_pulse_width", 32'(pbPulse), 32'h0);
        checkOutput("b3_level_hold", 32'(pbLevel), 32'h00008);
        pbRaw = '0;
        applyStimulus(6);
        checkOutput("b3_release_early", 32'(pbLevel), 32'h00008);
        applyStimulus(1);
        checkOutput("b3_release", 32'(pbLevel), 32'h0);
        applyStimulus(2);
        checkOutput("b3_pulse_count", 32'(pulseTally[3]), 32'd1);

        // Three-cycle glitch on button 5
        pbRaw = 20'h00020;
        applyStimulus(3);
        pbRaw = '0;
        applyStimulus(12);
        checkOutput("b5_glitch_level", 32'(pbLevel), 32'h0);
        checkOutput("b5_glitch_pulses", 32'(pulseTally[5]), 32'd0);
        checkOutput("b5_glitch_state", 32'(dut.g_btn[5].u_btn.r_state), 32'(LO));

        // Press, release, press on button 10
        pbRaw = 20'h00400;
        applyStimulus(7);
        checkOutput("b10_press1_level", 32'(pbLevel), 32'h00400);
        checkOutput("b10_press1_pulse", 32'(pbPulse), 32'h00400);
        applyStimulus(3);
        pbRaw = '0;
        applyStimulus(6);
        checkOutput("b10_rel_early", 32'(pbLevel), 32'h00400);
        applyStimulus(1);
        checkOutput("b10_released", 32'(pbLevel), 32'h0);
        pbRaw = 20'h00400;
        applyStimulus(7);
        checkOutput("b10_press2_level", 32'(pbLevel), 32'h00400);
        checkOutput("b10_press2_pulse", 32'(pbPulse), 32'h00400);
        pbRaw = '0;
        applyStimulus(9);
        checkOutput("b10_pulse_count", 32'(pulseTally[10]), 32'd2);
        checkOutput("b10_final_level", 32'(pbLevel), 32'h0);

        // Simultaneous press of buttons 0 and 7
        pbRaw = 20'h00081;
        applyStimulus(7);
        checkOutput("dual_pulse", 32'(pbPulse), 32'h00081);
        checkOutput("dual_multi", 32'(multiPress), 32'h1);
        applyStimulus(1);
        checkOutput("dual_pulse_off", 32'(pbPulse), 32'h0);
        checkOutput("dual_multi_held", 32'(multiPress), 32'h1);
        pbRaw = 20'h00080;
        applyStimulus(7);
        checkOutput("single_multi", 32'(multiPress), 32'h0);
        checkOutput("single_any", 32'(anyPress), 32'h1);
        checkOutput("single_level", 32'(pbLevel), 32'h00080);
        pbRaw = '0;
        applyStimulus(7);
        checkOutput("none_any", 32'(anyPress), 32'h0);

        // Reset while button 2 is held in HI
        pbRaw = 20'h00004;
        applyStimulus(7);
        checkOutput("b2_level", 32'(pbLevel), 32'h00004);
        applyStimulus(2);
        nrst = 1'b1;
        #1;
        checkOutput("b2_reset_level", 32'(pbLevel), 32'h0);
        checkOutput("b2_reset_pulse", 32'(pbPulse), 32'h0);
        applyStimulus(2);
        nrst = 1'b0;
        applyStimulus(6);
        checkOutput("b2_fresh_early", 32'(pbLevel), 32'h0);
        applyStimulus(1);
        checkOutput("b2_fresh_level", 32'(pbLevel), 32'h00004);
        checkOutput("b2_fresh_pulse", 32'(pbPulse), 32'h00004);
        pbRaw = '0;
        applyStimulus(9);
        checkOutput("b2_pulse_count", 32'(pulseTally[2]), 32'd2);

        // Long hold on button 1 (repeat-enabled)
        pbRaw = 20'h00002;
        applyStimulus(7);
        checkOutput("b1_first_pulse", 32'(pbPulse), 32'h00002);
        offsets.delete();
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(1);
            if (pbPulse[1]) offsets.push_back(k);
        end
`ifdef PB_CONDITIONER_AUTOREPEAT_EN
        checkOutput("b1_repeat_count", 32'(offsets.size()), 32'd4);
        if (offsets.size() == 4) begin
            checkOutput("b1_rep0", 32'(offsets[0]), 32'd20);
            checkOutput("b1_rep1", 32'(offsets[1]), 32'd26);
            checkOutput("b1_rep2", 32'(offsets[2]), 32'd32);
            checkOutput("b1_rep3", 32'(offsets[3]), 32'd38);
        end
`else
        checkOutput("b1_repeat_count", 32'(offsets.size()), 32'd0);
`endif
        pbRaw = '0;
        applyStimulus(9);
        checkOutput("b1_released", 32'(pbLevel), 32'h0);

        // Same long hold on button 4 (repeat masked off)
        pbRaw = 20'h00010;
        applyStimulus(7);
        checkOutput("b4_first_pulse", 32'(pbPulse), 32'h00010);
        offsets.delete();
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(1);
            if (pbPulse[4]) offsets.push_back(k);
        end
        checkOutput("b4_repeat_count", 32'(offsets.size()), 32'd0);
        pbRaw = '0;
        applyStimulus(9);
        checkOutput("b4_pulse_count", 32'(pulseTally[4]), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
